// File: rtl/frame_serializer.sv
// Serialises a header, snapshot frequency/time words and a checksum into a byte stream.
// Latency 1 from start to MAGIC; each byte is held with tx_valid until tx_ready accepts it.
module frame_serializer #(
    parameter int          NF    = 2,
    parameter int          NT    = 5,
    parameter int          WB    = 4,
    parameter logic [7:0]  MAGIC = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [NF*WB*8-1:0] fval,
    input  logic [NT*WB*8-1:0] tval,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE, HDR_MAGIC, HDR_MODE, FREQ, TIME, CSUM, FIN
    } state_t;

    localparam logic [3:0] F_LAST = 4'(NF - 1);
    localparam logic [3:0] T_LAST = 4'(NT - 1);
    localparam logic [1:0] B_LAST = 2'(WB - 1);

    state_t             state, state_nxt;
    logic [1:0]         mode_q;
    logic [NF*WB*8-1:0] fval_q;
    logic [NT*WB*8-1:0] tval_q;
    logic [3:0]         wcnt, wcnt_nxt;
    logic [1:0]         bcnt, bcnt_nxt;
    logic [7:0]         csum;
    logic               xfer;

    assign xfer = tx_valid & tx_ready;
    assign busy = (state != IDLE);
    assign done = (state == FIN);

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        bcnt_nxt  = bcnt;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (state)
            IDLE: begin
                if (start) state_nxt = HDR_MAGIC;
            end
            HDR_MAGIC: begin
                tx_valid = 1'b1;
                tx_data  = MAGIC;
                if (tx_ready) state_nxt = HDR_MODE;
            end
            HDR_MODE: begin
                tx_valid = 1'b1;
                tx_data  = {6'b0, mode_q};
                if (tx_ready) begin
                    bcnt_nxt = 2'd0;
                    if (mode_q[1]) begin
                        state_nxt = FREQ;
                        wcnt_nxt  = F_LAST;
                    end else if (mode_q[0]) begin
                        state_nxt = TIME;
                        wcnt_nxt  = T_LAST;
                    end else begin
                        state_nxt = CSUM;
                    end
                end
            end
            FREQ: begin
                tx_valid = 1'b1;
                // Words go highest index first, MSB byte first within a word.
                tx_data  = fval_q[int'(wcnt)*WB*8 + (WB-1-int'(bcnt))*8 +: 8];
                if (tx_ready) begin
                    if (bcnt == B_LAST) begin
                        bcnt_nxt = 2'd0;
                        if (wcnt == 4'd0) begin
                            if (mode_q[0]) begin
                                state_nxt = TIME;
                                wcnt_nxt  = T_LAST;
                            end else begin
                                state_nxt = CSUM;
                            end
                        end else begin
                            wcnt_nxt = wcnt - 4'd1;
                        end
                    end else begin
                        bcnt_nxt = bcnt + 2'd1;
                    end
                end
            end
            TIME: begin
                tx_valid = 1'b1;
                tx_data  = tval_q[int'(wcnt)*WB*8 + (WB-1-int'(bcnt))*8 +: 8];
                if (tx_ready) begin
                    if (bcnt == B_LAST) begin
                        bcnt_nxt = 2'd0;
                        if (wcnt == 4'd0) state_nxt = CSUM;
                        else              wcnt_nxt  = wcnt - 4'd1;
                    end else begin
                        bcnt_nxt = bcnt + 2'd1;
                    end
                end
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) state_nxt = FIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wcnt   <= 4'd0;
            bcnt   <= 2'd0;
            csum   <= 8'h00;
            mode_q <= 2'b00;
            fval_q <= '0;
            tval_q <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            bcnt  <= bcnt_nxt;
            if (state == IDLE && start) begin
                mode_q <= mode;
                fval_q <= fval;
                tval_q <= tval;
                csum   <= 8'h00;
            end else if (xfer && state != CSUM) begin
                csum <= csum + tx_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench for frame_serializer: expected bytes queued at start, popped on each transfer.
module tb_frame_serializer;

    localparam int NF = 2;
    localparam int NT = 5;
    localparam int WB = 4;
    localparam logic [7:0] MAGIC = 8'hFF;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [1:0]         mode = 2'b00;
    logic [NF*WB*8-1:0] fv = '0;
    logic [NT*WB*8-1:0] tv = '0;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready = 1'b1;
    logic               busy;
    logic               done;

    int n_chk  = 0;
    int n_fail = 0;
    int nbytes = 0;
    logic [7:0] exp_q[$];

    frame_serializer #(.NF(NF), .NT(NT), .WB(WB), .MAGIC(MAGIC)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .fval(fv), .tval(tv),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference frame built from the values the frame should capture.
    task automatic push_expected(input logic [1:0] m, output int len);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'h00;
        exp_q.push_back(MAGIC); sum += MAGIC;
        b = {6'b0, m};
        exp_q.push_back(b); sum += b;
        if (m[1])
            for (int k = NF-1; k >= 0; k--)
                for (int j = WB-1; j >= 0; j--) begin
                    b = fv[k*WB*8 + j*8 +: 8];
                    exp_q.push_back(b); sum += b;
                end
        if (m[0])
            for (int k = NT-1; k >= 0; k--)
                for (int j = WB-1; j >= 0; j--) begin
                    b = tv[k*WB*8 + j*8 +: 8];
                    exp_q.push_back(b); sum += b;
                end
        exp_q.push_back(sum);
        len = 3 + (m[1] ? NF*WB : 0) + (m[0] ? NT*WB : 0);
    endtask

    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            nbytes++;
            chk("byte_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("byte", tx_data, exp_q.pop_front());
        end
        if (!rst && done) begin
            chk("done_q_empty", exp_q.size(), 0);
            chk("done_no_valid", tx_valid, 0);
        end
    end

    // Runs one frame; optional stall and mid-frame input disturbance at given byte counts.
    task automatic run_frame(input logic [1:0] m, input int stall_at, input int chg_at);
        int   len, nbusy;
        logic fin, stalled, changed;
        logic [7:0] held;
        mode = m;
        push_expected(m, len);
        nbytes = 0; nbusy = 0;
        fin = 0; stalled = 0; changed = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("lat_valid", tx_valid, 1);
        chk("lat_magic", tx_data, MAGIC);
        for (int c = 0; c < 400 && !fin; c++) begin
            start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                fin = 1;
            end else if (stall_at >= 0 && nbytes == stall_at && !stalled) begin
                stalled = 1;
                held = tx_data;
                tx_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("stall_valid", tx_valid, 1);
                    chk("stall_data", tx_data, held);
                end
                tx_ready = 1'b1;
                nbusy += 5;
            end else if (chg_at >= 0 && nbytes == chg_at && !changed) begin
                changed = 1;
                for (int k = 0; k < NF; k++) fv[k*32 +: 32] = $urandom;
                for (int k = 0; k < NT; k++) tv[k*32 +: 32] = $urandom;
                mode  = ~m;
                start = 1'b1;
            end
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        chk("frame_done", fin, 1);
        chk("frame_len", nbytes, len);
        chk("busy_cycles", nbusy, len + 1 + (stalled ? 5 : 0));
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        run_frame(2'b00, -1, -1);

        fv = {32'h01020304, 32'h00000010};
        run_frame(2'b10, -1, -1);

        fv = '0; tv = '0;
        run_frame(2'b11, -1, -1);

        for (int k = 0; k < NF; k++) fv[k*32 +: 32] = $urandom;
        for (int k = 0; k < NT; k++) tv[k*32 +: 32] = $urandom;
        run_frame(2'b11, 5, -1);

        for (int k = 0; k < NF; k++) fv[k*32 +: 32] = $urandom;
        for (int k = 0; k < NT; k++) tv[k*32 +: 32] = $urandom;
        run_frame(2'b11, -1, 4);

        // Abort a frame in TIME, then prove a clean restart.
        for (int k = 0; k < NT; k++) tv[k*32 +: 32] = $urandom;
        begin
            int len;
            mode = 2'b01;
            push_expected(2'b01, len);
            nbytes = 0;
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < 50 && nbytes < 6; c++) begin
                @(posedge clk); #1;
            end
            chk("reach_time", 32'(nbytes >= 6), 1);
            rst = 1'b1;
            @(posedge clk); #1;
            chk("abort_valid", tx_valid, 0);
            chk("abort_busy", busy, 0);
            rst = 1'b0;
            exp_q.delete();
        end

        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_over_start", busy, 0);

        run_frame(2'b01, -1, -1);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NF; k++) fv[k*32 +: 32] = $urandom;
            for (int k = 0; k < NT; k++) tv[k*32 +: 32] = $urandom;
            run_frame(2'($urandom_range(3, 0)), -1, -1);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 SHALL have parameter NF, default 2, number of frequency words (1..15).
REQ-002 SHALL have parameter NT, default 5, number of time words (1..15).
REQ-003 SHALL have parameter WB, default 4, bytes per word (1..4).
REQ-004 SHALL have parameter MAGIC, default 8'hFF, frame header byte.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-008 SHALL have port mode  input  2  bit1 = send freq words, bit0 = send time words.
REQ-009 SHALL have port fval  input  NF*WB*8  word k at bits [k*WB*8 +: WB*8].
REQ-010 SHALL have port tval  input  NT*WB*8  word k at bits [k*WB*8 +: WB*8].
REQ-011 SHALL have port tx_data  output  8  current byte.
REQ-012 SHALL have port tx_valid  output  1  tx_data valid.
REQ-013 SHALL have port tx_ready  input  1  downstream byte sink accepts.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-016 SHALL use states IDLE, HDR_MAGIC, HDR_MODE, FREQ, TIME, CSUM, FIN.
REQ-017 SHALL, in IDLE with start=1, capture mode, fval and tval into internal snapshot registers and go to HDR_MAGIC; later input changes SHALL not affect the frame.
REQ-018 SHALL present the first byte (MAGIC) with tx_valid=1 in the cycle after start is sampled (latency 1).
REQ-019 SHALL count a byte as transferred only in a cycle where tx_valid=1 and tx_ready=1.
REQ-020 SHALL hold tx_data stable and tx_valid high until transferred; tx_valid SHALL not drop without a transfer except on rst.
REQ-021 SHALL emit bytes back-to-back: after a transfer, the next byte is valid in the following cycle (one byte per cycle at tx_ready=1).
REQ-022 SHALL send frame order: MAGIC; mode byte {6'b0, mode}; freq words if mode[1]; time words if mode[0]; checksum.
REQ-023 SHALL send words in index order NF-1 (or NT-1) down to 0, each MSB byte first, WB bytes per word.
REQ-024 SHALL skip FREQ when mode[1]=0 and TIME when mode[0]=0 with no idle cycle inserted.
REQ-025 SHALL compute checksum as the modulo-256 sum of every byte transferred in the frame before it, MAGIC included.
REQ-026 SHALL make frame length 3 + mode[1]*NF*WB + mode[0]*NT*WB bytes.
REQ-027 SHALL enter FIN after the checksum transfer, asserting done=1 for exactly that one cycle with tx_valid=0, then return to IDLE.
REQ-028 SHALL ignore start while busy=1; start high in FIN SHALL be ignored, and start held high into IDLE SHALL begin a new frame.
REQ-029 SHALL keep busy=1 from the cycle after start is sampled through FIN inclusive.
REQ-030 SHALL use word/byte counters sized for NF, NT (4 bits) and WB (2 bits), with no wrap beyond the configured counts.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, go to IDLE with tx_valid=0, tx_data=8'h00, busy=0, done=0, checksum cleared, counters zero.
REQ-032 SHALL abort any frame in progress on rst; tx_valid SHALL be 0 in the cycle after the reset edge and no partial frame SHALL resume.
REQ-033 SHALL give rst priority over start in the same cycle.

Verification
REQ-034 SHALL cover: defaults, mode=2'b00, tx_ready=1 -> bytes FF 00 FF, done pulse after 3rd transfer, 3 busy cycles plus FIN.
REQ-035 SHALL cover: mode=2'b10, fval[1]=32'h01020304, fval[0]=32'h00000010 -> FF 02 01 02 03 04 00 00 00 10 1B.
REQ-036 SHALL cover: mode=2'b11, all words 0 -> 3+28=31 bytes total, checksum = FF+03 = 8'h02.
REQ-037 SHALL cover: tx_ready held low 5 cycles mid-word -> tx_data/tx_valid unchanged, no byte lost or duplicated.
REQ-038 SHALL cover: fval/tval changed and start pulsed mid-frame -> frame bytes match the values captured at start; no new frame starts.
REQ-039 SHALL cover: rst asserted during TIME -> tx_valid=0, busy=0 the next cycle; a subsequent start yields a complete frame from MAGIC.
